// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// hazard_unit_mc : stall / flush / forward control for a 5-stage MIPS pipeline,
//                  including a fixed-latency multi-cycle divide hold in E.
// Revision 1.0
// ============================================================================
module hazard_unit_mc #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       memtoregE,
  input  logic       regwriteE,
  input  logic       divstartE,
  input  logic [4:0] writeregM,
  input  logic       memtoregM,
  input  logic       regwriteM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       divdoneE
);

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             divhold_q;
  logic             divdone_q;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  logic w_lwstall;
  logic w_branchstall;
  logic w_divstall;
  logic w_hazD;

  assign w_lwstall = memtoregE & (reg_hit(writeregE, rsD) | reg_hit(writeregE, rtD));

  assign w_branchstall = branchD &
      ((regwriteE & (reg_hit(writeregE, rsD) | reg_hit(writeregE, rtD))) |
       (memtoregM & (reg_hit(writeregM, rsD) | reg_hit(writeregM, rtD))));

  // First divide cycle is decoded from the input; the rest come from divhold_q.
  assign w_divstall = ((state_q == S_IDLE) & divstartE) | divhold_q;
  assign w_hazD     = w_lwstall | w_branchstall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      divhold_q <= 1'b0;
      divdone_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (divstartE) begin
            state_q   <= S_BUSY;
            cnt_q     <= c_CNT_LOAD;
            divhold_q <= (c_CNT_LOAD != '0);
            divdone_q <= (c_CNT_LOAD == '0);
          end else begin
            divhold_q <= 1'b0;
            divdone_q <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q     <= cnt_q - c_CNT_ONE;
            divhold_q <= (cnt_q != c_CNT_ONE);
            divdone_q <= (cnt_q == c_CNT_ONE);
          end else begin
            state_q   <= S_IDLE;
            divhold_q <= 1'b0;
            divdone_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    forwardaD = 1'b0;
    forwardbD = 1'b0;
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    divdoneE  = 1'b0;
    if (!rst) begin
      stallF    = w_hazD | w_divstall;
      stallD    = w_hazD | w_divstall;
      stallE    = w_divstall;
      flushE    = w_hazD & ~w_divstall;
      flushM    = w_divstall;
      forwardaD = regwriteM & reg_hit(writeregM, rsD);
      forwardbD = regwriteM & reg_hit(writeregM, rtD);
      divdoneE  = divdone_q;

      // M is younger than W, so its value takes priority.
      if (regwriteM & reg_hit(writeregM, rsE))      forwardaE = 2'b10;
      else if (regwriteW & reg_hit(writeregW, rsE)) forwardaE = 2'b01;

      if (regwriteM & reg_hit(writeregM, rtE))      forwardbE = 2'b10;
      else if (regwriteW & reg_hit(writeregW, rtE)) forwardbE = 2'b01;
    end
  end

endmodule
`default_nettype wire
